// File: rtl/mult_arbiter.sv
// Purpose: round-robin arbiter time-sharing one shift-and-add multiplier among N requesters.
// Latency: accept in cycle t, mult_valid in t+1, rsp_valid no earlier than t+3+multiplier latency.
// Backpressure: one operation in flight; req_ready held low outside IDLE, rsp_valid held until rsp_ready.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   per-requester request handshake (req_ready one-hot or zero, combinational in IDLE)
//   req_a/req_b       packed signed operands, slice i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready   per-requester result handshake (rsp_valid one-hot or zero)
//   rsp_product       shared 2*WIDTH+1 signed result bus, valid where rsp_valid is high
//   mult_*            interface to the shared multiplier (start pulse, operands, result, ready)
module mult_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [N-1:0]       rsp_valid,
  input  logic [N-1:0]       rsp_ready,
  output logic [2*WIDTH:0]   rsp_product,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  output logic               mult_valid,
  input  logic [2*WIDTH:0]   mult_product,
  input  logic               mult_ready
);

  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;   // also identifies the owner of the in-flight operation
  logic            blank;        // high during the first WAIT cycle, masks a stale mult_ready

  logic [GW-1:0]   grant_next;
  logic            grant_found;
  logic [N-1:0]    grant_oh;
  logic [N-1:0]    last_oh;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin pick: scan from last_grant+1 upward, wrapping at N-1.
  always_comb begin : rr_pick
    logic [GW-1:0] idx;
    grant_next  = last_grant;
    grant_found = 1'b0;
    idx         = last_grant;
    for (int k = 0; k < N; k++) begin
      idx = (idx == GW'(N - 1)) ? '0 : idx + GW'(1);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_next  = idx;
      end
    end
  end

  always_comb begin
    grant_oh             = '0;
    grant_oh[grant_next] = 1'b1;
    last_oh              = '0;
    last_oh[last_grant]  = 1'b1;
  end

  // Operand mux for the candidate requester; sampled only in the accept cycle.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_next == GW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept is combinational so the requester sees it in the same cycle it is chosen;
  // gated by reset so nothing is accepted while the block is being cleared.
  assign req_ready = (state == IDLE && !reset && grant_found) ? grant_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GW'(N - 1);
      blank       <= 1'b0;
      mult_valid  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            // Operands go straight into the multiplier-facing registers and stay
            // there untouched until the next accept.
            mult_a     <= sel_a;
            mult_b     <= sel_b;
            last_grant <= grant_next;
            mult_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mult_valid <= 1'b0;
          blank      <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          // A multiplier may not drop ready until a cycle after it samples the
          // start pulse, so the first WAIT cycle never trusts mult_ready.
          if (blank) begin
            blank <= 1'b0;
          end else if (mult_ready) begin
            rsp_product <= mult_product;
            rsp_valid   <= last_oh;
            state       <= RESP;
          end
        end
        RESP: begin
          // Only the owner's rsp_ready completes the handshake.
          if (rsp_ready[last_grant]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Interface invariants.
  a_req_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_mult_valid_pulse: assert property (@(posedge clk) disable iff (reset) mult_valid |=> !mult_valid);
  a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
      (|rsp_valid && !(|(rsp_valid & rsp_ready))) |=>
      (rsp_valid == $past(rsp_valid) && rsp_product == $past(rsp_product)));

endmodule

// File: tb/tb_mult_arbiter.sv
// Purpose: directed self-checking bench for mult_arbiter with a behavioural multiplier model.
// Latency: model result appears lat cycles after the start pulse (plus one in late-drop mode).
// Backpressure: rsp_ready driven per test; default all ones.
module tb_mult_arbiter;
  localparam int N  = 4;
  localparam int W  = 18;
  localparam int PW = 2*W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [PW-1:0]  rsp_product, mult_product;
  logic [W-1:0]   mult_a, mult_b;
  logic           mult_valid, mult_ready;

  int n_checks = 0;
  int n_pass   = 0;

  // Multiplier model state.
  int            lat       = 4;
  bit            late_mode = 1'b0;
  int            m_cnt     = 0;
  bit            m_pend    = 1'b0;
  logic [PW-1:0] m_res     = '0;
  logic [PW-1:0] m_out     = '0;

  mult_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .mult_a(mult_a), .mult_b(mult_b), .mult_valid(mult_valid),
    .mult_product(mult_product), .mult_ready(mult_ready)
  );

  always #5 clk = ~clk;

  // In late mode ready stays high for one cycle after the start pulse, with a stale result.
  always @(posedge clk) begin
    if (mult_valid) begin
      m_res <= {{(PW-W){mult_a[W-1]}}, mult_a} * {{(PW-W){mult_b[W-1]}}, mult_b};
      if (late_mode) begin
        m_pend <= 1'b1;
        m_cnt  <= 0;
      end else begin
        m_pend <= 1'b0;
        m_cnt  <= lat;
      end
    end else if (m_pend) begin
      m_pend <= 1'b0;
      m_cnt  <= lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_out <= m_res;
    end
  end
  assign mult_ready   = (m_cnt == 0);
  assign mult_product = m_out;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one request, waits for its accept and its response. Returns just after
  // the clock edge that ends the first response cycle. rcyc counts from the ISSUE cycle as 1.
  task automatic run_op(input logic [N-1:0] vld, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        output int gidx, output int rcyc, output logic [PW-1:0] prod,
                        output logic [N-1:0] rv, output int pulses, output int extra_rdy,
                        output logic [W-1:0] ma, output logic [W-1:0] mb);
    bit done;
    gidx = -1; rcyc = -1; prod = '0; rv = '0; pulses = 0; extra_rdy = 0; ma = '0; mb = '0;
    req_valid = vld; req_a = a; req_b = b;
    for (int t = 0; t < 20 && gidx < 0; t++) begin
      @(negedge clk);
      if (req_ready != '0) gidx = oh_idx(req_ready);
      @(posedge clk); #1;
    end
    req_valid = '0;
    done = (gidx < 0);
    for (int c = 1; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mult_valid) begin pulses++; ma = mult_a; mb = mult_b; end
      if (req_ready != '0) extra_rdy++;
      if (rsp_valid != '0) begin rv = rsp_valid; prod = rsp_product; rcyc = c; done = 1'b1; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_a = '1; req_b = '1; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready: got %b expected 0000", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); else n_pass++;
    n_checks++; if (mult_valid !== 1'b0) $display("FAIL rst_mult_valid: got %b expected 0", mult_valid); else n_pass++;
    n_checks++; if (mult_a !== 18'h0 || mult_b !== 18'h0) $display("FAIL rst_mult_ops: got %h/%h expected 0/0", mult_a, mult_b); else n_pass++;
    n_checks++; if (rsp_product !== 37'h0) $display("FAIL rst_rsp_product: got %h expected 0", rsp_product); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    int g, rc, pl, xr; logic [PW-1:0] p; logic [N-1:0] rv; logic [W-1:0] ma, mb;
    logic [N*W-1:0] a, b;
    do_reset(); lat = 19; late_mode = 1'b0;
    a = '0; b = '0;
    a[2*W +: W] = 18'd3; b[2*W +: W] = 18'h3FFFB;
    run_op(4'b0100, a, b, g, rc, p, rv, pl, xr, ma, mb);
    n_checks++; if (g !== 2) $display("FAIL single_grant: got %0d expected 2", g); else n_pass++;
    n_checks++; if (pl !== 1) $display("FAIL single_pulses: got %0d expected 1", pl); else n_pass++;
    n_checks++; if (ma !== 18'd3 || mb !== 18'h3FFFB) $display("FAIL single_mult_ops: got %h/%h expected 00003/3fffb", ma, mb); else n_pass++;
    n_checks++; if (xr !== 0) $display("FAIL single_extra_ready: got %0d expected 0", xr); else n_pass++;
    n_checks++; if (rc !== 22) $display("FAIL single_latency: got %0d expected 22", rc); else n_pass++;
    n_checks++; if (rv !== 4'b0100) $display("FAIL single_rsp_valid: got %b expected 0100", rv); else n_pass++;
    n_checks++; if (p !== -37'sd15) $display("FAIL single_product: got %0d expected -15", $signed(p)); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_clear: got %b expected 0000", rsp_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int g[6]; logic [N-1:0] rvv[6]; logic [PW-1:0] rp[6];
    int ng, nr, eg; int ep[4]; logic [N-1:0] eoh; logic signed [PW-1:0] e;
    do_reset(); lat = 3; late_mode = 1'b0;
    ep = '{70, -180, -3300, -52000};
    for (int k = 0; k < 6; k++) begin g[k] = -1; rvv[k] = '0; rp[k] = '0; end
    req_a = {18'h3F060, 18'd300, 18'h3FFEC, 18'd10};
    req_b = {18'd13, 18'h3FFF5, 18'd9, 18'd7};
    req_valid = '1; rsp_ready = '1;
    ng = 0; nr = 0;
    for (int cyc = 0; cyc < 300 && (ng < 6 || nr < 6); cyc++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 6) begin g[ng] = oh_idx(req_ready); ng++; end
      if (rsp_valid != '0 && nr < 6) begin rvv[nr] = rsp_valid; rp[nr] = rsp_product; nr++; end
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      eg = k % 4;
      eoh = '0; eoh[eg] = 1'b1;
      e = ep[eg];
      n_checks++; if (g[k] !== eg) $display("FAIL rr_grant%0d: got %0d expected %0d", k, g[k], eg); else n_pass++;
      n_checks++; if (rvv[k] !== eoh) $display("FAIL rr_rsp_valid%0d: got %b expected %b", k, rvv[k], eoh); else n_pass++;
      n_checks++; if (rp[k] !== e) $display("FAIL rr_product%0d: got %0d expected %0d", k, $signed(rp[k]), e); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int g, rc, pl, xr; logic [PW-1:0] p; logic [N-1:0] rv; logic [W-1:0] ma, mb;
    logic [N*W-1:0] a, b; int bad_v, bad_p, bad_m, bad_r;
    do_reset(); lat = 5; late_mode = 1'b0;
    rsp_ready = 4'b1101;
    a = '0; b = '0;
    a[1*W +: W] = 18'd1234; b[1*W +: W] = 18'h3FFC8;
    a[2*W +: W] = 18'd2;    b[2*W +: W] = 18'd2;
    run_op(4'b0010, a, b, g, rc, p, rv, pl, xr, ma, mb);
    n_checks++; if (g !== 1) $display("FAIL bp_grant: got %0d expected 1", g); else n_pass++;
    n_checks++; if (p !== -37'sd69104 || rv !== 4'b0010) $display("FAIL bp_first_rsp: got %0d/%b expected -69104/0010", $signed(p), rv); else n_pass++;
    req_valid = '1;
    bad_v = 0; bad_p = 0; bad_m = 0; bad_r = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0010) bad_v++;
      if (rsp_product !== -37'sd69104) bad_p++;
      if (mult_valid !== 1'b0) bad_m++;
      if (req_ready !== 4'b0000) bad_r++;
      @(posedge clk); #1;
    end
    n_checks++; if (bad_v !== 0) $display("FAIL bp_hold_valid: got %0d bad cycles expected 0", bad_v); else n_pass++;
    n_checks++; if (bad_p !== 0) $display("FAIL bp_hold_product: got %0d bad cycles expected 0", bad_p); else n_pass++;
    n_checks++; if (bad_m !== 0) $display("FAIL bp_no_issue: got %0d bad cycles expected 0", bad_m); else n_pass++;
    n_checks++; if (bad_r !== 0) $display("FAIL bp_no_accept: got %0d bad cycles expected 0", bad_r); else n_pass++;
    rsp_ready = '1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL bp_rsp_clear: got %b expected 0000", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL bp_next_grant: got %b expected 0100", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_extremes();
    int g, rc, pl, xr; logic [PW-1:0] p; logic [N-1:0] rv; logic [W-1:0] ma, mb;
    logic [N*W-1:0] a, b;
    do_reset(); lat = 6; late_mode = 1'b0;
    a = '0; b = '0;
    a[0 +: W] = 18'h20000; b[0 +: W] = 18'h20000;
    run_op(4'b0001, a, b, g, rc, p, rv, pl, xr, ma, mb);
    n_checks++; if (ma !== 18'h20000) $display("FAIL ext_mult_a: got %h expected 20000", ma); else n_pass++;
    n_checks++; if (rv !== 4'b0001) $display("FAIL ext_rsp_valid: got %b expected 0001", rv); else n_pass++;
    n_checks++; if (p !== 37'h4_0000_0000) $display("FAIL ext_pos_product: got %h expected 0400000000", p); else n_pass++;
    a = '0; b = '0;
    a[1*W +: W] = 18'h20000; b[1*W +: W] = 18'h1FFFF;
    run_op(4'b0010, a, b, g, rc, p, rv, pl, xr, ma, mb);
    n_checks++; if (rv !== 4'b0010) $display("FAIL ext_rsp_valid2: got %b expected 0010", rv); else n_pass++;
    n_checks++; if (p !== -37'sd17179738112) $display("FAIL ext_neg_product: got %0d expected -17179738112", $signed(p)); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int g, rc, pl, xr; logic [PW-1:0] p; logic [N-1:0] rv; logic [W-1:0] ma, mb;
    logic [N*W-1:0] a, b; int bad, rises; logic prev_rdy;
    do_reset(); lat = 10; late_mode = 1'b0;
    req_a = '0; req_b = '0;
    req_a[1*W +: W] = 18'd7; req_b[1*W +: W] = 18'd9;
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL rw_accept: got %b expected 0010", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (mult_valid !== 1'b1 || mult_a !== 18'd7) $display("FAIL rw_issue: got %b/%h expected 1/00007", mult_valid, mult_a); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (mult_valid !== 1'b0 || mult_a !== 18'h0 || mult_b !== 18'h0) $display("FAIL rw_mult_cleared: got %b/%h/%h expected 0/0/0", mult_valid, mult_a, mult_b); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) $display("FAIL rw_hs_cleared: got %b/%b expected 0000/0000", rsp_valid, req_ready); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0; rises = 0; prev_rdy = mult_ready;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || mult_valid !== 1'b0) bad++;
      if (mult_ready && !prev_rdy) rises++;
      prev_rdy = mult_ready;
      @(posedge clk); #1;
    end
    n_checks++; if (rises !== 1) $display("FAIL rw_model_finished: got %0d rises expected 1", rises); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL rw_no_stale_rsp: got %0d bad cycles expected 0", bad); else n_pass++;
    a = '0; b = '0;
    a[0 +: W] = 18'h3FED4; b[0 +: W] = 18'd11;
    a[2*W +: W] = 18'd5;   b[2*W +: W] = 18'd5;
    run_op(4'b0101, a, b, g, rc, p, rv, pl, xr, ma, mb);
    n_checks++; if (g !== 0) $display("FAIL rw_next_grant: got %0d expected 0", g); else n_pass++;
    n_checks++; if (p !== -37'sd3300 || rv !== 4'b0001) $display("FAIL rw_next_rsp: got %0d/%b expected -3300/0001", $signed(p), rv); else n_pass++;
  endtask

  task automatic test_blanking();
    int g, rc, pl, xr; logic [PW-1:0] p; logic [N-1:0] rv; logic [W-1:0] ma, mb;
    logic [N*W-1:0] a, b;
    do_reset(); lat = 4; late_mode = 1'b1;
    a = '0; b = '0;
    a[3*W +: W] = 18'h3FFE7; b[3*W +: W] = 18'd40;
    run_op(4'b1000, a, b, g, rc, p, rv, pl, xr, ma, mb);
    n_checks++; if (g !== 3) $display("FAIL blank_grant: got %0d expected 3", g); else n_pass++;
    n_checks++; if (rc !== 8) $display("FAIL blank_latency: got %0d expected 8", rc); else n_pass++;
    n_checks++; if (p !== -37'sd1000) $display("FAIL blank_product: got %0d expected -1000", $signed(p)); else n_pass++;
    n_checks++; if (rv !== 4'b1000) $display("FAIL blank_rsp_valid: got %b expected 1000", rv); else n_pass++;
    late_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_extremes();
    test_reset_in_wait();
    test_blanking();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
